// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI burst controller and its clock generator.
package spi_pkg;

    typedef enum logic [1:0] {
        OP_TX   = 2'b00,
        OP_RX   = 2'b01,
        OP_XFER = 2'b10
    } spi_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_STORE,
        ST_DONE
    } spi_state_t;

    localparam logic SPI_IDLE_MOSI = 1'b1;

    // The reserved encoding 2'b11 behaves as a read-only burst.
    function automatic spi_op_t decode_op(input logic [1:0] op_raw);
        spi_op_t res;
        case (op_raw)
            2'b00:   res = OP_TX;
            2'b10:   res = OP_XFER;
            default: res = OP_RX;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: sixteen half-periods of D+1 cycles per byte, low phase first,
// with strobes marking the rising edge, the inner falling edges and the byte end.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             sclk_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             byte_end_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [3:0]       phase_q, phase_d;
    logic             sclk_q, sclk_d;
    logic             tick;

    // Even phases are low, odd phases high; phase 15 ends the byte.
    assign tick       = en_i && (cnt_q == '0);
    assign rise_o     = tick && !phase_q[0];
    assign fall_o     = tick && phase_q[0] && (phase_q != 4'd15);
    assign byte_end_o = tick && (phase_q == 4'd15);
    assign sclk_o     = sclk_q;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        sclk_d  = sclk_q;
        if (!en_i) begin
            cnt_d   = div_i;
            phase_d = 4'd0;
            sclk_d  = 1'b0;
        end else if (tick) begin
            cnt_d   = div_i;
            phase_d = phase_q + 4'd1;
            sclk_d  = !phase_q[0];
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 4'd0;
            sclk_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            sclk_q  <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_burst_controller.sv
// SPI mode-0 burst master between a local byte memory and an SD card, with a
// runtime SCLK divider and TX / RX / full-duplex transfer modes.
module spi_burst_controller
    import spi_pkg::*;
#(
    parameter int          MEMORY_SIZE_IN_BYTES = 512,
    parameter int          DIV_W                = 8,
    parameter logic [7:0]  FILL_BYTE            = 8'hFF,
    localparam int         AW                   = $clog2(MEMORY_SIZE_IN_BYTES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [AW:0]      size,
    input  logic [DIV_W-1:0] clk_div,
    output logic [AW-1:0]    address,
    input  logic [7:0]       data_in,
    output logic [7:0]       data_out,
    output logic             wr,
    output logic             busy,
    output logic             done,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso
);

    localparam logic [AW:0] REM_LAST = 1;

    spi_state_t       state_q, state_d;
    spi_op_t          op_q;
    logic [DIV_W-1:0] div_q;
    logic [AW:0]      rem_q;
    logic [AW-1:0]    addr_q;
    logic [7:0]       tx_q;
    logic [7:0]       rx_q;
    logic [7:0]       load_byte;
    logic             accept;
    logic             rise, fall, byte_end;

    assign accept    = (state_q == ST_IDLE) && start;
    assign load_byte = (op_q == OP_RX) ? FILL_BYTE : data_in;

    spi_clk_gen #(
        .DIV_W(DIV_W)
    ) u_clk_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (state_q == ST_SHIFT),
        .div_i      (div_q),
        .sclk_o     (sclk),
        .rise_o     (rise),
        .fall_o     (fall),
        .byte_end_o (byte_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = (size == '0) ? ST_DONE : ST_LOAD;
            ST_LOAD:  state_d = ST_SHIFT;
            ST_SHIFT: if (byte_end) state_d = ST_STORE;
            ST_STORE: state_d = (rem_q == REM_LAST) ? ST_DONE : ST_LOAD;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
        wr   = (state_q == ST_STORE) && (op_q != OP_TX);
    end

    assign address  = addr_q;
    assign data_out = rx_q;
    assign mosi     = tx_q[7];

    // Burst parameters are captured once so later input changes cannot disturb a running burst.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= decode_op(op);
            div_q <= clk_div;
            rem_q <= size;
        end else if (state_q == ST_STORE) begin
            rem_q <= rem_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            rx_q   <= 8'h00;
            tx_q   <= {8{SPI_IDLE_MOSI}};
        end else begin
            if (accept) begin
                addr_q <= '0;
            end else if (state_q == ST_STORE) begin
                addr_q <= addr_q + 1'b1;
            end

            if (rise) begin
                rx_q <= {rx_q[6:0], miso};
            end

            // MOSI returns to its idle level whenever the bus is leaving the data phase.
            if ((state_d == ST_DONE) || (state_d == ST_IDLE)) begin
                tx_q <= {8{SPI_IDLE_MOSI}};
            end else if (state_q == ST_LOAD) begin
                tx_q <= load_byte;
            end else if (fall) begin
                tx_q <= {tx_q[6:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_spi_burst_controller.sv
// Directed bench for spi_burst_controller: table of bursts plus reset and mid-burst start sequences.
module tb_spi_burst_controller;

    localparam int MEM   = 512;
    localparam int AW    = 9;
    localparam int DIV_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [1:0]       op;
    logic [AW:0]      size;
    logic [DIV_W-1:0] clk_div;
    logic [AW-1:0]    address;
    logic [7:0]       data_in;
    logic [7:0]       data_out;
    logic             wr;
    logic             busy;
    logic             done;
    logic             sclk;
    logic             mosi;
    logic             miso;

    always #5 clk = ~clk;

    spi_burst_controller #(
        .MEMORY_SIZE_IN_BYTES(MEM),
        .DIV_W               (DIV_W),
        .FILL_BYTE           (8'hFF)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .size     (size),
        .clk_div  (clk_div),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out),
        .wr       (wr),
        .busy     (busy),
        .done     (done),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso)
    );

    logic [7:0] rd_mem [0:MEM-1];
    logic [7:0] wr_mem [0:MEM-1];
    assign data_in = rd_mem[address];

    // SPI slave model: counts SCLK rising edges, captures MOSI, serves MISO bytes MSB first.
    logic       loop_en;
    logic [7:0] slave_b [0:3];
    logic [7:0] mosi_cap [0:3];
    int         bit_cnt = 0;
    int         base    = 0;
    int         rel;

    always_comb begin
        rel  = bit_cnt - base;
        miso = loop_en ? mosi : slave_b[rel[4:3]][~rel[2:0]];
    end

    always @(posedge sclk) begin
        mosi_cap[rel[4:3]] <= {mosi_cap[rel[4:3]][6:0], mosi};
        bit_cnt <= bit_cnt + 1;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    int r_done, r_wr, r_first, r_hmin, r_hmax;
    bit r_busy_ok;

    task automatic run_burst(input logic [1:0] o, input int sz, input int d,
                             input int limit, input int pulse_at);
        int cyc;
        int hi_run;
        @(negedge clk);
        op      = o;
        size    = (AW+1)'(sz);
        clk_div = DIV_W'(d);
        start   = 1'b1;
        base    = bit_cnt;
        @(posedge clk);
        #1;
        start     = 1'b0;
        op        = 2'($urandom_range(0, 3));
        size      = (AW+1)'($urandom_range(0, MEM));
        clk_div   = DIV_W'($urandom_range(0, 255));
        cyc       = 1;
        hi_run    = 0;
        r_done    = -1;
        r_wr      = 0;
        r_first   = -1;
        r_hmin    = 1000;
        r_hmax    = 0;
        r_busy_ok = 1'b1;
        while (cyc <= limit) begin
            start = (cyc == pulse_at);
            if (!busy) r_busy_ok = 1'b0;
            if (wr) begin
                r_wr++;
                if (r_first < 0) r_first = cyc;
                wr_mem[address] = data_out;
            end
            if (sclk) begin
                hi_run++;
            end else if (hi_run > 0) begin
                if (hi_run < r_hmin) r_hmin = hi_run;
                if (hi_run > r_hmax) r_hmax = hi_run;
                hi_run = 0;
            end
            if (done) begin
                r_done = cyc;
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
    endtask

    typedef struct packed {
        logic [1:0]      op;
        logic [9:0]      size;
        logic [7:0]      div;
        logic            lp;
        logic [3:0][7:0] tx;
        logic [3:0][7:0] sl;
        logic [15:0]     exp_done;
        logic [7:0]      exp_wr;
        logic [15:0]     exp_first;
        logic [3:0][7:0] exp_mosi;
        logic [3:0][7:0] exp_wmem;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{op:2'b00, size:10'd3, div:8'd0, lp:1'b0,
                    tx:{8'h00, 8'hFF, 8'h3C, 8'hA5}, sl:32'h0,
                    exp_done:16'd55, exp_wr:8'd0, exp_first:16'd0,
                    exp_mosi:{8'h00, 8'hFF, 8'h3C, 8'hA5}, exp_wmem:32'h0};
        vecs[1] = '{op:2'b01, size:10'd2, div:8'd1, lp:1'b0,
                    tx:{8'h11, 8'h22, 8'h33, 8'h44}, sl:{8'h00, 8'h00, 8'h81, 8'h5A},
                    exp_done:16'd69, exp_wr:8'd2, exp_first:16'd34,
                    exp_mosi:{8'h00, 8'h00, 8'hFF, 8'hFF}, exp_wmem:{8'h00, 8'h00, 8'h81, 8'h5A}};
        vecs[2] = '{op:2'b10, size:10'd4, div:8'd3, lp:1'b1,
                    tx:{8'h7E, 8'hC3, 8'h80, 8'h01}, sl:32'h0,
                    exp_done:16'd265, exp_wr:8'd4, exp_first:16'd66,
                    exp_mosi:{8'h7E, 8'hC3, 8'h80, 8'h01}, exp_wmem:{8'h7E, 8'hC3, 8'h80, 8'h01}};
        vecs[3] = '{op:2'b00, size:10'd0, div:8'd2, lp:1'b0,
                    tx:32'h0, sl:32'h0,
                    exp_done:16'd1, exp_wr:8'd0, exp_first:16'd0,
                    exp_mosi:32'h0, exp_wmem:32'h0};
        vecs[4] = '{op:2'b11, size:10'd1, div:8'd0, lp:1'b0,
                    tx:{8'h00, 8'h00, 8'h00, 8'h55}, sl:{8'h00, 8'h00, 8'h00, 8'hC3},
                    exp_done:16'd19, exp_wr:8'd1, exp_first:16'd18,
                    exp_mosi:{8'h00, 8'h00, 8'h00, 8'hFF}, exp_wmem:{8'h00, 8'h00, 8'h00, 8'hC3}};

        for (int a = 0; a < MEM; a++) begin
            rd_mem[a] = 8'h00;
            wr_mem[a] = 8'h00;
        end
        for (int b = 0; b < 4; b++) slave_b[b] = 8'h00;
        loop_en = 1'b0;
        rst_n   = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        size    = '0;
        clk_div = '0;

        repeat (5) begin
            @(negedge clk);
            start   = 1'($urandom_range(0, 1));
            op      = 2'($urandom_range(0, 3));
            size    = (AW+1)'($urandom_range(0, MEM));
            clk_div = DIV_W'($urandom_range(0, 255));
        end
        chk("reset_sclk", int'(sclk), 0);
        chk("reset_mosi", int'(mosi), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_wr", int'(wr), 0);
        chk("reset_address", int'(address), 0);
        chk("reset_data_out", int'(data_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            for (int b = 0; b < 4; b++) begin
                rd_mem[b]  = vecs[i].tx[b];
                slave_b[b] = vecs[i].sl[b];
                wr_mem[b]  = 8'hEE;
            end
            loop_en = vecs[i].lp;
            run_burst(vecs[i].op, int'(vecs[i].size), int'(vecs[i].div), 400, -1);
            $display("vector %0d: done at cycle %0d, %0d writes", i, r_done, r_wr);
            chk($sformatf("v%0d_done_cycle", i), r_done, int'(vecs[i].exp_done));
            chk($sformatf("v%0d_wr_count", i), r_wr, int'(vecs[i].exp_wr));
            chk($sformatf("v%0d_busy", i), int'(r_busy_ok), 1);
            chk($sformatf("v%0d_sclk_rises", i), bit_cnt - base, 8 * int'(vecs[i].size));
            if (vecs[i].exp_wr > 0)
                chk($sformatf("v%0d_first_wr", i), r_first, int'(vecs[i].exp_first));
            if (vecs[i].size > 0) begin
                chk($sformatf("v%0d_high_min", i), r_hmin, int'(vecs[i].div) + 1);
                chk($sformatf("v%0d_high_max", i), r_hmax, int'(vecs[i].div) + 1);
            end
            for (int b = 0; b < int'(vecs[i].size); b++) begin
                chk($sformatf("v%0d_mosi_byte%0d", i, b), int'(mosi_cap[b]), int'(vecs[i].exp_mosi[b]));
                if (vecs[i].exp_wr > 0)
                    chk($sformatf("v%0d_mem_byte%0d", i, b), int'(wr_mem[b]), int'(vecs[i].exp_wmem[b]));
            end
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_idle_busy", i), int'(busy), 0);
            chk($sformatf("v%0d_idle_done", i), int'(done), 0);
            chk($sformatf("v%0d_idle_mosi", i), int'(mosi), 1);
        end

        // Extra start pulse in the middle of a burst must not alter it.
        loop_en   = 1'b0;
        rd_mem[0] = 8'hA5;
        rd_mem[1] = 8'h3C;
        run_burst(2'b00, 2, 0, 100, 10);
        chk("midstart_done_cycle", r_done, 37);
        chk("midstart_sclk_rises", bit_cnt - base, 16);
        chk("midstart_mosi_byte1", int'(mosi_cap[1]), 8'h3C);
        @(posedge clk);
        #1;
        chk("midstart_idle_busy", int'(busy), 0);

        // Reset during bit 3 of the second byte of an RX burst, D=1.
        slave_b[0] = 8'h5A;
        slave_b[1] = 8'h81;
        @(negedge clk);
        op      = 2'b01;
        size    = (AW+1)'(2);
        clk_div = DIV_W'(1);
        start   = 1'b1;
        base    = bit_cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        chk("rstmid_sclk_high_before", int'(sclk), 1);
        chk("rstmid_address_before", int'(address), 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_sclk", int'(sclk), 0);
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_mosi", int'(mosi), 1);
        chk("rstmid_address", int'(address), 0);
        begin
            int done_seen;
            done_seen = 0;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                if (done || busy || wr) done_seen++;
            end
            chk("rstmid_no_activity", done_seen, 0);
        end

        slave_b[0] = 8'h96;
        wr_mem[0]  = 8'hEE;
        run_burst(2'b01, 1, 0, 100, -1);
        chk("after_rst_done_cycle", r_done, 19);
        chk("after_rst_wr_count", r_wr, 1);
        chk("after_rst_mem0", int'(wr_mem[0]), 8'h96);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
